// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: owner encoding, completion tag and latency limits.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
    logic   we;
  } tag_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 3;
  // Wide enough to hold MEM_LAT_MAX-1 busy cycles
  localparam int unsigned BUSY_W      = 2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, DM) and memory-macro signals of the arbiter, grouped as one bus.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_valid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;

  // Pipeline requesters and memory macro
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if
  );

  // Arbiter
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if
  );
endinterface

// File: rtl/mem_arb_tag_pipe.sv
// MEM_LAT-deep shift register carrying each access's owner/we to its completion cycle.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign tag_out = stg[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter, DM over IF, with tagged completion routing.
// Optional IF starvation guard enabled by defining STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX || STARVE_MAX == 0) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LAT must be 1..3 and STARVE_MAX nonzero");
  end

  logic [BUSY_W-1:0] busy_cnt;
  logic              free_c, issue_c, pick_dm_c, if_gnt_c, dm_gnt_c;
  tag_t              tag_in, tag_out;

`ifdef STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic          force_if_c;

  assign force_if_c = bus.if_req && (starve_cnt == SW'(STARVE_MAX));

  // Counts DM wins over a waiting IF; any IF grant or idle IF restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || if_gnt_c) begin
      starve_cnt <= '0;
    end else if (dm_gnt_c && starve_cnt != SW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  logic force_if_c;
  assign force_if_c = 1'b0;
`endif

  // Grant selection and memory-side mux; rst_n gating keeps everything idle in reset
  always_comb begin
    free_c        = rst_n && (busy_cnt == '0);
    issue_c       = free_c && (bus.if_req || bus.dm_req);
    pick_dm_c     = bus.dm_req && !force_if_c;
    dm_gnt_c      = issue_c && pick_dm_c;
    if_gnt_c      = issue_c && !pick_dm_c;
    bus.dm_gnt    = dm_gnt_c;
    bus.if_gnt    = if_gnt_c;
    bus.mem_en    = issue_c;
    bus.mem_we    = dm_gnt_c && bus.dm_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (dm_gnt_c) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else if (if_gnt_c) begin
      bus.mem_addr  = bus.if_addr;
    end
    bus.stall_if  = rst_n && bus.if_req && !if_gnt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (issue_c) begin
      busy_cnt <= BUSY_W'(MEM_LAT - 1);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
    end
  end

  always_comb begin
    tag_in.vld   = issue_c;
    tag_in.owner = dm_gnt_c ? OWN_DM : OWN_IF;
    tag_in.we    = dm_gnt_c && bus.dm_we;
  end

  mem_arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_comb begin
    bus.if_valid = tag_out.vld && (tag_out.owner == OWN_IF);
    bus.dm_valid = tag_out.vld && (tag_out.owner == OWN_DM);
    bus.if_rdata = bus.if_valid ? bus.mem_rdata : '0;
    bus.dm_rdata = (bus.dm_valid && !tag_out.we) ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT 1, 2 and 3 against a shared memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1, rst2, rst3;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(8), .DW(8)) b1 ();
  mem_port_arbiter_if #(.AW(8), .DW(8)) b2 ();
  mem_port_arbiter_if #(.AW(8), .DW(8)) b3 ();

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_MAX(4)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));
  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(2), .STARVE_MAX(4)) u2 (.clk(clk), .rst_n(rst2), .bus(b2));
  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .STARVE_MAX(4)) u3 (.clk(clk), .rst_n(rst3), .bus(b3));

  // Memory model: write at the issue edge, read data emerges MEM_LAT cycles after mem_en
  logic [7:0] mem [256];
  logic [7:0] q1, q2a, q2b, q3a, q3b, q3c;

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem[b1.mem_addr] <= b1.mem_wdata;
    else if (b2.mem_en && b2.mem_we) mem[b2.mem_addr] <= b2.mem_wdata;
    else if (b3.mem_en && b3.mem_we) mem[b3.mem_addr] <= b3.mem_wdata;
    q1  <= b1.mem_en ? mem[b1.mem_addr] : 8'h00;
    q2a <= b2.mem_en ? mem[b2.mem_addr] : 8'h00;
    q2b <= q2a;
    q3a <= b3.mem_en ? mem[b3.mem_addr] : 8'h00;
    q3b <= q3a;
    q3c <= q3b;
  end

  assign b1.mem_rdata = q1;
  assign b2.mem_rdata = q2b;
  assign b3.mem_rdata = q3c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle; inputs change here, checks follow after #1
  task automatic cyc();
    @(negedge clk);
  endtask

  logic [6:0] exp_dm;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    q1 = 0; q2a = 0; q2b = 0; q3a = 0; q3b = 0; q3c = 0;
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    b1.if_req = 1'b1; b1.if_addr = 8'h10; b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 8'h30; b1.dm_wdata = 8'h00;
    b2.if_req = 1'b0; b2.if_addr = 8'h00; b2.dm_req = 1'b0; b2.dm_we = 1'b0; b2.dm_addr = 8'h00; b2.dm_wdata = 8'h00;
    b3.if_req = 1'b0; b3.if_addr = 8'h00; b3.dm_req = 1'b0; b3.dm_we = 1'b0; b3.dm_addr = 8'h00; b3.dm_wdata = 8'h00;

    // Test 1: reset holds everything idle despite requests; release grants DM at once
    cyc(); #1;
    chk("rst_dm_gnt",   32'(b1.dm_gnt),   32'd0);
    chk("rst_if_gnt",   32'(b1.if_gnt),   32'd0);
    chk("rst_mem_en",   32'(b1.mem_en),   32'd0);
    chk("rst_stall_if", 32'(b1.stall_if), 32'd0);
    chk("rst_valid",    32'({b1.if_valid, b1.dm_valid}), 32'd0);
    cyc(); rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; #1;
    chk("rel_dm_gnt",   32'(b1.dm_gnt),   32'd1);
    chk("rel_if_gnt",   32'(b1.if_gnt),   32'd0);
    chk("rel_stall_if", 32'(b1.stall_if), 32'd1);
    cyc(); b1.if_req = 1'b0; b1.dm_req = 1'b0; #1;
    chk("rel_dm_valid", 32'(b1.dm_valid), 32'd1);
    chk("rel_dm_rdata", 32'(b1.dm_rdata), 32'h5A);

    // Test 2: MEM_LAT=1 fetch
    cyc(); b1.if_req = 1'b1; b1.if_addr = 8'h10; #1;
    chk("if_gnt",      32'(b1.if_gnt),   32'd1);
    chk("if_mem_en",   32'(b1.mem_en),   32'd1);
    chk("if_mem_we",   32'(b1.mem_we),   32'd0);
    chk("if_mem_addr", 32'(b1.mem_addr), 32'h10);
    cyc(); b1.if_req = 1'b0; #1;
    chk("if_valid",    32'(b1.if_valid), 32'd1);
    chk("if_rdata",    32'(b1.if_rdata), 32'hA5);
    chk("if_no_dmv",   32'(b1.dm_valid), 32'd0);
    chk("idle_addr",   32'(b1.mem_addr), 32'd0);

    // Test 4: DM write then read-back
    cyc(); b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 8'h20; b1.dm_wdata = 8'h3C; #1;
    chk("wr_gnt",      32'(b1.dm_gnt),    32'd1);
    chk("wr_mem_we",   32'(b1.mem_we),    32'd1);
    chk("wr_mem_addr", 32'(b1.mem_addr),  32'h20);
    chk("wr_mem_data", 32'(b1.mem_wdata), 32'h3C);
    cyc(); b1.dm_we = 1'b0; #1;
    chk("wr_dm_valid", 32'(b1.dm_valid),  32'd1);
    chk("wr_no_ifv",   32'(b1.if_valid),  32'd0);
    chk("rd_mem_we",   32'(b1.mem_we),    32'd0);
    cyc(); b1.dm_req = 1'b0; #1;
    chk("rd_dm_rdata", 32'(b1.dm_rdata),  32'h3C);

    // Test 5: both requests held for 7 cycles
`ifdef STARVE_GUARD_EN
    exp_dm = 7'b1101111;
`else
    exp_dm = 7'b1111111;
`endif
    for (int i = 0; i < 7; i++) begin
      cyc(); b1.if_req = 1'b1; b1.dm_req = 1'b1; b1.dm_addr = 8'h30; #1;
      chk($sformatf("hold_dm_gnt%0d", i), 32'(b1.dm_gnt), 32'(exp_dm[i]));
      chk($sformatf("hold_if_gnt%0d", i), 32'(b1.if_gnt), 32'(!exp_dm[i]));
    end
    cyc(); b1.if_req = 1'b0; b1.dm_req = 1'b0;

    // Test 3: MEM_LAT=2 contention
    cyc(); b2.if_req = 1'b1; b2.if_addr = 8'h10; b2.dm_req = 1'b1; b2.dm_addr = 8'h30; #1;
    chk("l2_dm_gnt_t",   32'(b2.dm_gnt),   32'd1);
    chk("l2_if_gnt_t",   32'(b2.if_gnt),   32'd0);
    chk("l2_stall_t",    32'(b2.stall_if), 32'd1);
    cyc(); b2.dm_req = 1'b0; #1;
    chk("l2_if_gnt_t1",  32'(b2.if_gnt),   32'd0);
    chk("l2_stall_t1",   32'(b2.stall_if), 32'd1);
    chk("l2_mem_en_t1",  32'(b2.mem_en),   32'd0);
    chk("l2_dmv_t1",     32'(b2.dm_valid), 32'd0);
    cyc(); #1;
    chk("l2_if_gnt_t2",  32'(b2.if_gnt),   32'd1);
    chk("l2_stall_t2",   32'(b2.stall_if), 32'd0);
    chk("l2_dmv_t2",     32'(b2.dm_valid), 32'd1);
    chk("l2_dmrd_t2",    32'(b2.dm_rdata), 32'h5A);
    cyc(); b2.if_req = 1'b0; #1;
    chk("l2_ifv_t3",     32'(b2.if_valid), 32'd0);
    cyc(); #1;
    chk("l2_ifv_t4",     32'(b2.if_valid), 32'd1);
    chk("l2_ifrd_t4",    32'(b2.if_rdata), 32'hA5);

    // Test 6: MEM_LAT=3 reset mid-access discards the in-flight read
    cyc(); b3.dm_req = 1'b1; b3.dm_addr = 8'h10; #1;
    chk("l3_gnt_t",      32'(b3.dm_gnt),   32'd1);
    cyc(); b3.dm_req = 1'b0; rst3 = 1'b0; #1;
    chk("l3_rst_gnt",    32'(b3.dm_gnt),   32'd0);
    chk("l3_rst_mem_en", 32'(b3.mem_en),   32'd0);
    chk("l3_rst_dmv",    32'(b3.dm_valid), 32'd0);
    cyc(); rst3 = 1'b1; b3.dm_req = 1'b1; b3.dm_addr = 8'h30; #1;
    chk("l3_post_gnt",   32'(b3.dm_gnt),   32'd1);
    chk("l3_dmv_t2",     32'(b3.dm_valid), 32'd0);
    cyc(); b3.dm_req = 1'b0; #1;
    chk("l3_dmv_t3",     32'(b3.dm_valid), 32'd0);
    cyc(); #1;
    chk("l3_dmv_t4",     32'(b3.dm_valid), 32'd0);
    cyc(); #1;
    chk("l3_dmv_t5",     32'(b3.dm_valid), 32'd1);
    chk("l3_dmrd_t5",    32'(b3.dm_rdata), 32'h5A);
    cyc(); #1;
    chk("l3_dmv_t6",     32'(b3.dm_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
